// File: rtl/tdm_mux_if.sv
// TDM mux bus: frame request/data in, serialized slot stream out.
interface tdm_mux_if #(
  parameter int NCH = 8
);
  localparam int SW = $clog2(NCH);

  logic          start;
  logic          cont;
  logic [NCH-1:0] d;
  logic          y;
  logic [SW-1:0] sel;
  logic          valid;
  logic          frame;
  logic          done;

  // Source side: requests frames and supplies channel data.
  modport master (
    output start, cont, d,
    input  y, sel, valid, frame, done
  );

  // Mux side: serializes captured data one slot per cycle.
  modport slave (
    input  start, cont, d,
    output y, sel, valid, frame, done
  );
endinterface

// File: rtl/tdm_mux.sv
// 8-channel TDM serializer. D is snapshotted at frame start (and at the
// wrap in continuous mode) so the outgoing frame is immune to D changes.
// All outputs are registered; nothing combinational reaches the bus.
module tdm_mux #(
  parameter int NCH = 8
) (
  input logic        clk,
  input logic        rst,
  tdm_mux_if.slave   bus
);
  localparam int SW = $clog2(NCH);
  localparam logic [SW-1:0] LAST = SW'(NCH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state;
  logic [NCH-1:0]  shadow;
  logic [SW-1:0]   sel_q;
  logic [SW-1:0]   sel_nxt;
  logic            y_q;
  logic            valid_q;
  logic            frame_q;
  logic            done_q;

  assign sel_nxt = sel_q + SW'(1);

  // Frame FSM: Y is precomputed from the slot being entered so it stays a
  // pure register output aligned with SEL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shadow  <= '0;
      sel_q   <= '0;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= SEND;
            shadow  <= bus.d;
            sel_q   <= '0;
            y_q     <= bus.d[0];
            valid_q <= 1'b1;
            frame_q <= 1'b1;
          end
        end
        SEND: begin
          if (sel_q == LAST) begin
            if (bus.cont) begin
              // chain straight into the next frame, no idle gap
              shadow  <= bus.d;
              sel_q   <= '0;
              y_q     <= bus.d[0];
              frame_q <= 1'b1;
            end else begin
              state   <= IDLE;
              sel_q   <= '0;
              y_q     <= 1'b0;
              valid_q <= 1'b0;
              frame_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            sel_q   <= sel_nxt;
            y_q     <= shadow[sel_nxt];
            frame_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.y     = y_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;
  assign bus.frame = frame_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_tdm_mux.sv
// Directed bench for tdm_mux: reset, single frames, one-hot sweep,
// continuous chaining, mid-frame abort, ignored START, START on DONE.
module tb_tdm_mux;
  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  tdm_mux_if #(.NCH(8)) bus ();

  tdm_mux #(.NCH(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // advance one edge, sample 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // compare {y, sel, valid, frame, done}
  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {bus.y, bus.sel, bus.valid, bus.frame, bus.done};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s obs{y,sel,v,f,d}=%b exp=%b", tag, obs, exp);
  endtask

  // Called while at slot 0; checks all 8 slots, ends at slot 7.
  // D is disturbed at slot 3; START pulsed at edge leaving slot pulse_k.
  task automatic check_slots(input string tag, input logic [7:0] data,
                             input logic [7:0] dmid, input int pulse_k);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_s%0d", tag, k),
          {data[k], 3'(k), 1'b1, (k == 0), 1'b0});
      if (k == 3) bus.d = dmid;
      bus.start = (k == pulse_k);
      if (k < 7) tick();
    end
    bus.start = 1'b0;
  endtask

  // start a non-chained frame, check it, DONE cycle and following idle
  task automatic single(input string tag, input logic [7:0] data);
    bus.d = data; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_slots(tag, data, ~data, -1);
    tick();
    chk({tag, "_done"}, 7'b0000001);
    tick();
    chk({tag, "_idle"}, 7'b0000000);
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b1; bus.cont = 1'b0; bus.d = 8'hFF;
    // reset held 2 cycles with START and D=FF
    tick(); chk("rst0", 7'b0000000);
    tick(); chk("rst1", 7'b0000000);
    rst = 1'b0; bus.start = 1'b0;
    tick(); chk("idle0", 7'b0000000);
    tick(); chk("idle1", 7'b0000000);

    single("one", 8'b1011_0010);

    for (int n = 0; n < 8; n++) begin
      logic [7:0] oh;
      oh = 8'(1 << n);
      single($sformatf("oh%0d", n), oh);
    end

    // continuous: A5 then 3C captured at wrap
    bus.cont = 1'b1; bus.d = 8'hA5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_slots("c1", 8'hA5, 8'h3C, -1);
    tick();
    bus.cont = 1'b0;
    check_slots("c2", 8'h3C, 8'h00, -1);
    tick(); chk("c_done", 7'b0000001);
    tick(); chk("c_idle", 7'b0000000);

    // abort at SEL=4
    bus.d = 8'h5A; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("ab_s4", {1'b1, 3'd4, 1'b1, 1'b0, 1'b0});
    rst = 1'b1;
    tick(); chk("ab_rst", 7'b0000000);
    rst = 1'b0;
    tick(); chk("ab_rel0", 7'b0000000);
    tick(); chk("ab_rel1", 7'b0000000);
    single("ab_new", 8'hC3);

    // START at SEL=3 ignored; START on DONE accepted
    bus.d = 8'h96; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_slots("ig", 8'h96, 8'hFF, 3);
    tick(); chk("ig_done", 7'b0000001);
    bus.d = 8'h0F; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_slots("sd", 8'h0F, 8'hF0, -1);
    tick(); chk("sd_done", 7'b0000001);
    tick(); chk("sd_idle", 7'b0000000);

    // first START honoured on first edge after reset release
    rst = 1'b1; bus.start = 1'b1; bus.d = 8'h81;
    tick(); chk("r1_rst", 7'b0000000);
    rst = 1'b0;
    tick();
    bus.start = 1'b0;
    check_slots("r1", 8'h81, 8'h7E, -1);
    tick(); chk("r1_done", 7'b0000001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
